// File: rtl/tjrpu_pkg.sv
// tjrpu_pkg -- definitions shared by the tjrpu Wishbone slave-side decode path.
//   wb_state_e        : decoder FSM states (IDLE / WAIT / RESP)
//   BASE_PREFIX_DFLT  : default address prefix (adr[31:24]) of the decoded region
//   ERR_DATA_DFLT     : default read data returned on a miss or timeout
//   *_SLV             : slave-window indices inside the decoded region
//   slv_idx_w()       : width of the slave-index field for a given slave count
package tjrpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam logic [7:0]  BASE_PREFIX_DFLT = 8'h30;
    localparam logic [31:0] ERR_DATA_DFLT    = 32'hDEAD_BEEF;

    localparam int TRI_SLV  = 0;
    localparam int CSR_SLV  = 1;
    localparam int MEM_SLV  = 2;
    localparam int DBG_SLV  = 3;

    // A single window still needs a 1-bit field so the part-select stays legal.
    function automatic int slv_idx_w(input int nslv);
        return (nslv > 1) ? $clog2(nslv) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// wb_addr_match -- combinational address decode for the tjrpu slave windows.
//   adr    in  32    master address
//   hit    out 1     prefix matches and slave index is below NSLV
//   slv_oh out NSLV  one-hot strobe vector for the decoded slave (all 0 on a miss)
module wb_addr_match
    import tjrpu_pkg::*;
#(
    parameter int          NSLV        = 4,
    parameter logic [7:0]  BASE_PREFIX = BASE_PREFIX_DFLT,
    parameter int          SEL_LSB     = 16
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [NSLV-1:0]  slv_oh
);

    localparam int IW = slv_idx_w(NSLV);

    logic [IW-1:0] idx;
    logic          unused_adr;

    assign idx        = adr[SEL_LSB +: IW];
    assign hit        = (adr[31:24] == BASE_PREFIX) && (32'(idx) < NSLV);
    assign unused_adr = ^adr;

    always_comb begin
        slv_oh = '0;
        for (int k = 0; k < NSLV; k++) begin
            slv_oh[k] = hit && (32'(idx) == k);
        end
    end

endmodule

// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder -- Wishbone classic slave-side decoder for tjrpu.
// Decodes each master cycle to one of NSLV slave windows, forwards the
// latched request to that slave and returns its ack/read data. Misses and
// slaves that do not ack within TIMEOUT cycles complete with ERR_DATA and
// an err_o pulse, so the master never stalls.
//   wb_clk_i, wb_rst_i            clock, async active-high reset
//   wbs_cyc/stb/we/sel/adr/dat_i  master request
//   wbs_ack_o, wbs_dat_o          registered completion to master
//   slv_stb_o                     registered one-hot slave strobes
//   slv_cyc_o, slv_we_o           registered cycle / write enable to slave
//   slv_sel_o, slv_adr_o, slv_dat_o  latched request fields
//   slv_ack_i, slv_dat_i          per-slave ack and read data (slave k at [32k+31:32k])
//   err_o                         one-cycle pulse on miss or timeout
module wb_slave_decoder
    import tjrpu_pkg::*;
#(
    parameter int          NSLV        = 4,
    parameter logic [7:0]  BASE_PREFIX = BASE_PREFIX_DFLT,
    parameter int          SEL_LSB     = 16,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DFLT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [NSLV-1:0]    slv_stb_o,
    output logic               slv_cyc_o,
    output logic               slv_we_o,
    output logic [3:0]         slv_sel_o,
    output logic [31:0]        slv_adr_o,
    output logic [31:0]        slv_dat_o,
    input  logic [NSLV-1:0]    slv_ack_i,
    input  logic [NSLV*32-1:0] slv_dat_i,
    output logic               err_o
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    wb_state_e         state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              hit;
    logic [NSLV-1:0]   hit_oh;
    logic              sel_ack;
    logic [31:0]       rd_mux;

    logic              ack_nxt, err_nxt, cyc_nxt, we_nxt;
    logic [31:0]       wbs_dat_nxt, adr_nxt, dat_nxt;
    logic [3:0]        sel_nxt;
    logic [NSLV-1:0]   stb_nxt;

    wb_addr_match #(
        .NSLV        (NSLV),
        .BASE_PREFIX (BASE_PREFIX),
        .SEL_LSB     (SEL_LSB)
    ) u_match (
        .adr    (wbs_adr_i),
        .hit    (hit),
        .slv_oh (hit_oh)
    );

    // The strobe vector is one-hot on the active slave while in WAIT, so it
    // doubles as the ack/data select; acks from other slaves are masked off.
    assign sel_ack = |(slv_ack_i & slv_stb_o);

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (slv_stb_o[k]) rd_mux = slv_dat_i[32*k +: 32];
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        wbs_dat_nxt = wbs_dat_o;
        stb_nxt     = slv_stb_o;
        cyc_nxt     = slv_cyc_o;
        we_nxt      = slv_we_o;
        sel_nxt     = slv_sel_o;
        adr_nxt     = slv_adr_o;
        dat_nxt     = slv_dat_o;

        case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_nxt = wbs_adr_i;
                    dat_nxt = wbs_dat_i;
                    sel_nxt = wbs_sel_i;
                    we_nxt  = wbs_we_i;
                    if (hit) begin
                        stb_nxt   = hit_oh;
                        cyc_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = WAIT;
                    end else begin
                        wbs_dat_nxt = ERR_DATA;
                        ack_nxt     = 1'b1;
                        err_nxt     = 1'b1;
                        state_nxt   = RESP;
                    end
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    stb_nxt   = '0;
                    cyc_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (sel_ack) begin
                    wbs_dat_nxt = rd_mux;
                    stb_nxt     = '0;
                    cyc_nxt     = 1'b0;
                    ack_nxt     = 1'b1;
                    state_nxt   = RESP;
                end else if (cnt == CNT_LAST) begin
                    wbs_dat_nxt = ERR_DATA;
                    stb_nxt     = '0;
                    cyc_nxt     = 1'b0;
                    ack_nxt     = 1'b1;
                    err_nxt     = 1'b1;
                    state_nxt   = RESP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                stb_nxt   = '0;
                cyc_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            err_o     <= 1'b0;
            slv_stb_o <= '0;
            slv_cyc_o <= 1'b0;
            slv_we_o  <= 1'b0;
            slv_sel_o <= '0;
            slv_adr_o <= '0;
            slv_dat_o <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wbs_ack_o <= ack_nxt;
            wbs_dat_o <= wbs_dat_nxt;
            err_o     <= err_nxt;
            slv_stb_o <= stb_nxt;
            slv_cyc_o <= cyc_nxt;
            slv_we_o  <= we_nxt;
            slv_sel_o <= sel_nxt;
            slv_adr_o <= adr_nxt;
            slv_dat_o <= dat_nxt;
        end
    end

endmodule

// File: doc/wb_slave_decoder.md
Name: wb_slave_decoder

Overview:
Wishbone classic slave-side decoder inside tjrpu. It sits directly downstream of the management SoC Wishbone slave port (wbs_*) and upstream of the core's decoded slaves (the tri_wbs_stb/ack group and its siblings). It decodes each master cycle to one of NSLV slave windows and routes strobe, write data, ack and read data between the master and that slave. Unmapped addresses and hung slaves complete with an error word, so the management core never stalls.

Parameters:
NSLV, 4, number of decoded slave windows (index width = clog2(NSLV)).
BASE_PREFIX, 8'h30, required value of wbs_adr_i[31:24] for any decode hit.
SEL_LSB, 16, LSB of the slave-index field; slave index = wbs_adr_i[SEL_LSB +: clog2(NSLV)].
TIMEOUT, 255, WAIT-state cycle limit before forced completion (legal range 1..65535).
ERR_DATA, 32'hDEAD_BEEF, read data returned on a miss or timeout.

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous, active-high reset
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master cycle, strobe, write enable
wbs_sel_i  in  4  master byte selects
wbs_adr_i  in  32  master address
wbs_dat_i  in  32  master write data
wbs_ack_o  out  1  ack to master, registered
wbs_dat_o  out  32  read data to master, registered
slv_stb_o  out  NSLV  one-hot slave strobes, registered
slv_cyc_o, slv_we_o  out  1 each  registered copies of cyc and we for the active slave
slv_sel_o  out  4  latched byte selects
slv_adr_o  out  32  latched address
slv_dat_o  out  32  latched write data
slv_ack_i  in  NSLV  per-slave ack
slv_dat_i  in  NSLV*32  per-slave read data; slave k occupies [32k+31:32k]
err_o  out  1  one-cycle pulse on a miss or timeout

Behaviour:
- Reset: one clock, wb_clk_i. wb_rst_i is asynchronous and active-high. While it is asserted: state = IDLE; all outputs = 0; counter = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, cyc & stb sampled high:
  - Latch adr, dat, sel and we.
  - Prefix match and index < NSLV: set slv_stb_o[idx] and slv_cyc_o; go WAIT; counter = 0.
  - Otherwise: wbs_dat_o = ERR_DATA; wbs_ack_o = 1; err_o = 1; go RESP.
- WAIT, each edge:
  - Master dropped cyc: clear all slave strobes and cyc; go IDLE; no ack, no err.
  - Else slv_ack_i[idx] = 1: capture slv_dat_i[idx] (writes: capture anyway, master ignores it); clear strobes and cyc; wbs_ack_o = 1; go RESP.
  - Else counter == TIMEOUT-1: clear strobes and cyc; wbs_dat_o = ERR_DATA; wbs_ack_o = 1; err_o = 1; go RESP.
  - Else counter += 1.
  - Priority: abort > ack > timeout.
- RESP: wbs_ack_o is high for exactly this one cycle; err_o is cleared; go IDLE unconditionally. The master drops stb on the edge where it sees ack, so IDLE never re-issues the same request.
- Latency:
  - Hit, slave acks in its first strobe cycle: wbs_ack_o rises 2 edges after the request is sampled.
  - Miss: 1 edge.
  - Timeout: TIMEOUT+1 edges.
- Acks from non-selected slaves, and acks arriving outside WAIT, are ignored.
- At most one slave strobe is asserted at any time.
- slv_adr_o, slv_dat_o and slv_sel_o hold their latched values until the next IDLE acceptance.
- wbs_dat_o holds its last value until the next completion.
- Reset asserted mid-transaction: immediate return to IDLE with all strobes and ack low. A slave ack that arrives later is ignored.

Decomposition:
- Shared package tjrpu_pkg holds: the state enum (IDLE/WAIT/RESP), the BASE_PREFIX and ERR_DATA defaults, and slave-index localparams (TRI_SLV = 0, etc.).
- One natural sub-module: wb_addr_match. It is purely combinational, takes the address and returns hit plus the one-hot slave vector, and can be unit-tested standalone.
- The FSM, counter and mux stay in the top module.

Test Plan:
- Read hit: adr = 0x3001_0004, slave 1 acks on its first strobe cycle with 0x1234_5678 -> only slv_stb_o = 4'b0010; wbs_ack_o high 2 edges after the request for 1 cycle; wbs_dat_o = 0x1234_5678.
- Write hit: adr = 0x3003_0000, dat = 0xA5A5_A5A5, sel = 4'b0011 -> slv_stb_o = 4'b1000; slv_we_o = 1; slv_dat_o = 0xA5A5_A5A5; slv_sel_o = 4'b0011; single ack.
- Unmapped access: adr = 0x2000_0000 -> no slave strobe; ack after 1 edge; wbs_dat_o = 0xDEAD_BEEF; err_o pulses once.
- Hung slave with TIMEOUT = 8: slave 2 never acks -> strobe held 8 cycles then dropped; ack with 0xDEAD_BEEF; err_o = 1.
- Master abort: cyc drops 3 cycles into WAIT, then slave 0 acks one cycle later -> strobe cleared; no wbs_ack_o; FSM returns to IDLE.
- Async reset: wb_rst_i asserted mid-WAIT, between clock edges -> slv_stb_o = 0 and wbs_ack_o = 0 immediately; the next request decodes normally.
